// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory-controller request driver: target codes,
// channel state encoding, per-channel beat counts and beat formatting helpers.
package mem_req_pkg;

    localparam logic [1:0] TGT_SDRAM = 2'd0;
    localparam logic [1:0] TGT_FLASH = 2'd1;
    localparam logic [1:0] TGT_ROM   = 2'd2;
    localparam logic [1:0] TGT_RSVD  = 2'd3;

    localparam int SDRAM_BEATS = 3;
    localparam int FLASH_BEATS = 4;
    localparam int ROM_BEATS   = 4;

    typedef enum logic [1:0] {IDLE, ARMED, SEND, GUARD} chan_state_e;
    typedef enum logic [1:0] {SLICE2, FIRST4, BIT1} data_mode_e;

    // Index of the final beat: a nonzero length truncates, but never extends, the frame.
    function automatic logic [1:0] last_beat(input logic [2:0] full, input logic [1:0] len);
        logic [2:0] n;
        if (len == 2'd0 || {1'b0, len} > full) n = full;
        else n = {1'b0, len};
        return 2'(n - 3'd1);
    endfunction

    function automatic logic [3:0] beat_data(input data_mode_e mode, input logic [3:0] d,
                                             input logic [1:0] k);
        logic [3:0] r;
        r = 4'h0;
        case (mode)
            SLICE2: begin
                if (k == 2'd0) r = {2'b00, d[1:0]};
                else if (k == 2'd1) r = {2'b00, d[3:2]};
            end
            FIRST4: if (k == 2'd0) r = d;
            BIT1:   r = {3'b000, d[k]};
            default: r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_req_chan.sv
// One transmit channel: latches a request, waits for a qualified go, sends its
// beats with valid high, then holds valid low for a guard period.
module mem_req_chan
    import mem_req_pkg::*;
#(
    parameter int         FULL_BEATS   = 4,
    parameter data_mode_e DATA_MODE    = SLICE2,
    parameter int         GUARD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        accept,
    input  logic [3:0]  acc_data,
    input  logic [1:0]  acc_len,
    input  logic        go,
    input  logic        ready_i,
    output logic        valid,
    output logic [3:0]  data,
    output logic        busy,
    output logic        done,
    output logic        launch,
    output chan_state_e state
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    chan_state_e     state_n;
    logic [1:0]      beat_q, beat_n;
    logic [GW-1:0]   guard_q, guard_n;
    logic [3:0]      d_q, d_n;
    logic [1:0]      last_q, last_n;
    logic            valid_n;
    logic [3:0]      data_n;

    assign busy   = (state != IDLE);
    assign launch = (state == ARMED) && go && ready_i;
    assign done   = (state == GUARD) && (guard_q == GUARD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            beat_q  <= '0;
            guard_q <= '0;
            d_q     <= '0;
            last_q  <= '0;
            valid   <= 1'b0;
            data    <= '0;
        end else begin
            state   <= state_n;
            beat_q  <= beat_n;
            guard_q <= guard_n;
            d_q     <= d_n;
            last_q  <= last_n;
            valid   <= valid_n;
            data    <= data_n;
        end
    end

    // valid/data are computed for the cycle after the edge, so a beat is a pure register output.
    always_comb begin
        state_n = state;
        beat_n  = beat_q;
        guard_n = guard_q;
        d_n     = d_q;
        last_n  = last_q;
        valid_n = 1'b0;
        data_n  = 4'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = ARMED;
                    d_n     = acc_data;
                    last_n  = last_beat(3'(FULL_BEATS), acc_len);
                end
            end
            ARMED: begin
                if (go && ready_i) begin
                    state_n = SEND;
                    beat_n  = 2'd0;
                    valid_n = 1'b1;
                    data_n  = beat_data(DATA_MODE, d_q, 2'd0);
                end
            end
            SEND: begin
                if (beat_q == last_q) begin
                    state_n = GUARD;
                    guard_n = '0;
                end else begin
                    beat_n  = beat_q + 2'd1;
                    valid_n = 1'b1;
                    data_n  = beat_data(DATA_MODE, d_q, beat_q + 2'd1);
                end
            end
            GUARD: begin
                if (guard_q == GUARD_LAST) state_n = IDLE;
                else guard_n = guard_q + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/mem_req_driver.sv
// Three-channel request driver: routes accepted requests to per-channel
// serialisers and launches armed channels together on a go pulse.
module mem_req_driver
    import mem_req_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int COUNT_W      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [1:0]         req_target,
    input  logic [3:0]         req_data,
    input  logic [1:0]         req_len,
    output logic               req_ready,
    output logic               req_err,
    input  logic               go,
    input  logic               sdram_ready_i,
    input  logic               flash_ready_i,
    input  logic               rom_ready_i,
    output logic               sdram_valid,
    output logic [1:0]         sdram_data,
    output logic               flash_valid,
    output logic [3:0]         flash_data,
    output logic               rom_valid,
    output logic [0:0]         rom_data,
    output logic [2:0]         chan_busy,
    output logic [2:0]         done,
    output logic [COUNT_W-1:0] frame_count
);

    logic [2:0]  accept;
    logic [2:0]  launch;
    logic [1:0]  n_launch;
    logic [3:0]  sd_d, fl_d, rm_d;
    chan_state_e st_sdram, st_flash, st_rom;
    logic        unused_dbg;

    // Request handshake: a request transfers on any cycle with req_valid && req_ready.
    // req_ready is purely a function of req_target and channel occupancy, never of req_valid.
    always_comb begin
        req_ready = 1'b1;
        case (req_target)
            TGT_SDRAM: req_ready = !chan_busy[0];
            TGT_FLASH: req_ready = !chan_busy[1];
            TGT_ROM:   req_ready = !chan_busy[2];
            default:   req_ready = 1'b1;
        endcase
    end

    assign accept[0] = req_valid && req_ready && (req_target == TGT_SDRAM);
    assign accept[1] = req_valid && req_ready && (req_target == TGT_FLASH);
    assign accept[2] = req_valid && req_ready && (req_target == TGT_ROM);
    assign n_launch  = {1'b0, launch[0]} + {1'b0, launch[1]} + {1'b0, launch[2]};

    always_ff @(posedge clock) begin
        if (reset) begin
            req_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            req_err     <= req_valid && (req_target == TGT_RSVD);
            frame_count <= frame_count + COUNT_W'(n_launch);
        end
    end

    mem_req_chan #(.FULL_BEATS(SDRAM_BEATS), .DATA_MODE(SLICE2), .GUARD_CYCLES(GUARD_CYCLES)) u_sdram (
        .clock(clock), .reset(reset), .accept(accept[0]), .acc_data(req_data), .acc_len(req_len),
        .go(go), .ready_i(sdram_ready_i), .valid(sdram_valid), .data(sd_d), .busy(chan_busy[0]),
        .done(done[0]), .launch(launch[0]), .state(st_sdram)
    );

    mem_req_chan #(.FULL_BEATS(FLASH_BEATS), .DATA_MODE(FIRST4), .GUARD_CYCLES(GUARD_CYCLES)) u_flash (
        .clock(clock), .reset(reset), .accept(accept[1]), .acc_data(req_data), .acc_len(req_len),
        .go(go), .ready_i(flash_ready_i), .valid(flash_valid), .data(fl_d), .busy(chan_busy[1]),
        .done(done[1]), .launch(launch[1]), .state(st_flash)
    );

    mem_req_chan #(.FULL_BEATS(ROM_BEATS), .DATA_MODE(BIT1), .GUARD_CYCLES(GUARD_CYCLES)) u_rom (
        .clock(clock), .reset(reset), .accept(accept[2]), .acc_data(req_data), .acc_len(req_len),
        .go(go), .ready_i(rom_ready_i), .valid(rom_valid), .data(rm_d), .busy(chan_busy[2]),
        .done(done[2]), .launch(launch[2]), .state(st_rom)
    );

    assign sdram_data = sd_d[1:0];
    assign flash_data = fl_d;
    assign rom_data   = rm_d[0];

    // Upper data bits of the narrow channels are always zero; channel states are for probing.
    assign unused_dbg = ^{sd_d[3:2], rm_d[3:1], st_sdram, st_flash, st_rom};

endmodule
